// File: rtl/gmii_pkg.sv
// Shared constants, state encoding and width helper for the GMII transmit scheduler.
package gmii_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    DRAIN,
    IFG
  } tx_state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer
// and moves the pointer just past the winner when the grant is taken.
module rr_arbiter
  import gmii_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req,
  input  logic                          en,
  output logic [NUM_SRC-1:0]            grant,
  output logic [idx_width(NUM_SRC)-1:0] grant_idx
);

  localparam int IW = idx_width(NUM_SRC);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Rotating-priority search starting at the pointer.
  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_SRC);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Advance the pointer past the winner whenever a grant is taken.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/gmii_tx_scheduler.sv
// Round-robin frame scheduler onto a GMII transmit interface: preamble/SFD
// insertion, cut-through payload, underrun signalling with drain, and IFG.
module gmii_tx_scheduler
  import gmii_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [8*NUM_SRC-1:0]          s_data,
  input  logic [NUM_SRC-1:0]            s_valid,
  input  logic [NUM_SRC-1:0]            s_last,
  output logic [NUM_SRC-1:0]            s_ready,
  output logic [7:0]                    gmii_txd,
  output logic                          gmii_tx_en,
  output logic                          gmii_tx_er,
  output logic                          busy,
  output logic [idx_width(NUM_SRC)-1:0] grant_idx
);

  localparam int IW      = idx_width(NUM_SRC);
  localparam int CNT_MAX = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]      grant_nxt;
  logic [7:0]         txd_nxt;
  logic               en_nxt;
  logic               er_nxt;

  logic               arb_en;
  logic [NUM_SRC-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;

  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (s_valid),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign busy = (state != IDLE);

  // Route the granted source's byte stream to the line datapath.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[8*i +: 8];
      end
    end
  end

  // Accept strobe: follows valid while forwarding, forced high while draining.
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IW'(i)) begin
        if (state == SFD || state == DATA) begin
          s_ready[i] = s_valid[i];
        end else if (state == DRAIN) begin
          s_ready[i] = 1'b1;
        end
      end
    end
  end

  // Next state and next line byte; the line registers lag the state by one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_nxt = grant_idx;
    txd_nxt   = '0;
    en_nxt    = 1'b0;
    er_nxt    = 1'b0;
    arb_en    = 1'b0;
    case (state)
      IDLE: begin
        arb_en = 1'b1;
        if (|arb_grant) begin
          grant_nxt = arb_idx;
          state_nxt = PREAMBLE;
          cnt_nxt   = CNT_W'(1);
          txd_nxt   = PREAMBLE_BYTE;
          en_nxt    = 1'b1;
        end
      end
      PREAMBLE: begin
        en_nxt = 1'b1;
        if (cnt >= CNT_W'(PREAMBLE_LEN)) begin
          txd_nxt   = SFD_BYTE;
          state_nxt = SFD;
          cnt_nxt   = '0;
        end else begin
          txd_nxt = PREAMBLE_BYTE;
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SFD, DATA: begin
        en_nxt = 1'b1;
        if (sel_valid) begin
          txd_nxt = sel_data;
          if (sel_last) begin
            // The IFG state's first cycle still shows this byte, so count from 0.
            state_nxt = IFG;
            cnt_nxt   = '0;
          end else begin
            state_nxt = DATA;
          end
        end else begin
          er_nxt    = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) begin
          // Line is already idle here, so the first IFG cycle is a low cycle.
          state_nxt = IFG;
          cnt_nxt   = CNT_W'(1);
        end
      end
      IFG: begin
        if (cnt >= CNT_W'(IFG_CYCLES)) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, grant and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      grant_idx  <= '0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      grant_idx  <= grant_nxt;
      gmii_txd   <= txd_nxt;
      gmii_tx_en <= en_nxt;
      gmii_tx_er <= er_nxt;
    end
  end

endmodule

// File: tb/tb_gmii_tx_scheduler.sv
// Directed self-checking bench for gmii_tx_scheduler (2 sources, 7-byte preamble, 12-cycle IFG).
module tb_gmii_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic [1:0]  s_valid;
  logic [1:0]  s_last;
  logic [1:0]  s_ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic        busy;
  logic [0:0]  grant_idx;

  gmii_tx_scheduler #(
    .NUM_SRC      (2),
    .PREAMBLE_LEN (7),
    .IFG_CYCLES   (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .busy       (busy),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Source queues: {gap_before, last, data}
  logic [9:0] srcq [2][$];

  // Line monitor logs
  logic [8:0] line_log [$];   // {tx_er, txd} of every tx_en cycle
  logic [8:0] exp_q    [$];
  int pre_log   [$];          // cycle of first tx_en-high cycle of each burst
  int end_log   [$];          // cycle of last tx_en-high cycle of each burst
  int fall_log  [$];          // first cycle with busy low after busy high
  int grant_log [$];
  int cyc       = 0;
  int er_cnt    = 0;
  int rdy_cnt0  = 0;
  int bad_ready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic push_byte(input int src, input logic [7:0] d, input logic last, input logic gap);
    srcq[src].push_back({gap, last, d});
  endtask

  task automatic exp_preamble();
    for (int k = 0; k < 7; k++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
  endtask

  task automatic clear_logs();
    line_log.delete(); exp_q.delete(); pre_log.delete(); end_log.delete();
    fall_log.delete(); grant_log.delete(); rdy_cnt0 = 0;
  endtask

  task automatic check_line(input string tag);
    check({tag, "_len"}, line_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < line_log.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), line_log[k], exp_q[k]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int  n = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #1;
      n++;
      done = (srcq[0].size() == 0) && (srcq[1].size() == 0) && !busy;
    end
    check({tag, "_timeout"}, !done, 1'b0);
  endtask

  // Source model: presents queue heads, pops on accept, inserts one idle cycle on a gap flag.
  initial begin : source_driver
    logic [1:0] acc;
    logic [9:0] head;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      acc = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() == 0) begin
          s_valid[i] = 1'b0; s_last[i] = 1'b0; s_data[8*i +: 8] = 8'h00;
        end else if (srcq[i][0][9]) begin
          head = srcq[i].pop_front();
          head[9] = 1'b0;
          srcq[i].push_front(head);
          s_valid[i] = 1'b0; s_last[i] = 1'b0;
        end else begin
          s_valid[i] = 1'b1;
          s_last[i]  = srcq[i][0][8];
          s_data[8*i +: 8] = srcq[i][0][7:0];
        end
      end
    end
  end

  // Line monitor sampled mid-cycle.
  initial begin : line_monitor
    logic prev_en   = 1'b0;
    logic prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (gmii_tx_en) line_log.push_back({gmii_tx_er, gmii_txd});
      if (gmii_tx_en && !prev_en) begin
        pre_log.push_back(cyc);
        grant_log.push_back(int'(grant_idx));
      end
      if (!gmii_tx_en && prev_en) end_log.push_back(cyc - 1);
      if (prev_busy && !busy) fall_log.push_back(cyc);
      if (gmii_tx_er) er_cnt++;
      if (s_ready[0]) rdy_cnt0++;
      if ((s_ready & ~(2'b01 << grant_idx)) != 2'b00) bad_ready++;
      prev_en   = gmii_tx_en;
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx_en", gmii_tx_en, 1'b0);
    check("rst_tx_er", gmii_tx_er, 1'b0);
    check("rst_txd", gmii_txd, 8'h00);
    check("rst_s_ready", s_ready, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_idx, 1'b0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Simultaneous 2-byte requests: src0 then src1, 14-cycle frame-to-frame spacing
    clear_logs();
    push_byte(0, 8'hA1, 1'b0, 1'b0); push_byte(0, 8'hA2, 1'b1, 1'b0);
    push_byte(1, 8'hB1, 1'b0, 1'b0); push_byte(1, 8'hB2, 1'b1, 1'b0);
    exp_preamble(); exp_q.push_back(9'h0A1); exp_q.push_back(9'h0A2);
    exp_preamble(); exp_q.push_back(9'h0B1); exp_q.push_back(9'h0B2);
    wait_done("sim", 200);
    check_line("sim");
    check("sim_span0", at(end_log, 0) - at(pre_log, 0) + 1, 10);
    check("sim_span1", at(end_log, 1) - at(pre_log, 1) + 1, 10);
    check("sim_gap", at(pre_log, 1) - at(end_log, 0), 14);
    check("sim_grant0", at(grant_log, 0), 0);
    check("sim_grant1", at(grant_log, 1), 1);

    // Single 4-byte frame from src0
    clear_logs();
    push_byte(0, 8'h11, 1'b0, 1'b0); push_byte(0, 8'h22, 1'b0, 1'b0);
    push_byte(0, 8'h33, 1'b0, 1'b0); push_byte(0, 8'h44, 1'b1, 1'b0);
    exp_preamble();
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h033); exp_q.push_back(9'h044);
    wait_done("single", 200);
    check_line("single");
    check("single_span", at(end_log, 0) - at(pre_log, 0) + 1, 12);
    check("single_busy_fall", at(fall_log, 0) - at(end_log, 0), 13);
    check("single_grant", at(grant_log, 0), 0);

    // Underrun on src1 after two bytes, then three drained bytes
    clear_logs();
    push_byte(1, 8'h61, 1'b0, 1'b0); push_byte(1, 8'h62, 1'b0, 1'b0);
    push_byte(1, 8'h63, 1'b0, 1'b1); push_byte(1, 8'h64, 1'b0, 1'b0);
    push_byte(1, 8'h65, 1'b1, 1'b0);
    exp_preamble(); exp_q.push_back(9'h061); exp_q.push_back(9'h062); exp_q.push_back(9'h100);
    wait_done("urun", 200);
    check_line("urun");
    check("urun_span", at(end_log, 0) - at(pre_log, 0) + 1, 11);
    check("urun_busy_fall", at(fall_log, 0) - at(end_log, 0), 15);
    check("urun_grant", at(grant_log, 0), 1);

    // Asynchronous reset in the middle of a src0 payload
    clear_logs();
    for (int i = 0; i < 10; i++) push_byte(0, 8'(8'h80 + i), (i == 9), 1'b0);
    n = 0;
    while (line_log.size() < 10 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("arst_reached_data", line_log.size() >= 10, 1'b1);
    check("arst_pre_tx_en", gmii_tx_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_tx_en", gmii_tx_en, 1'b0);
    check("arst_tx_er", gmii_tx_er, 1'b0);
    check("arst_s_ready", s_ready, 2'b00);
    check("arst_busy", busy, 1'b0);
    srcq[0].delete();
    srcq[1].delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    clear_logs();
    // Single-byte frames from both: pointer back at 0 means src0 goes first
    push_byte(0, 8'h5A, 1'b1, 1'b0);
    push_byte(1, 8'hA5, 1'b1, 1'b0);
    exp_preamble(); exp_q.push_back(9'h05A);
    exp_preamble(); exp_q.push_back(9'h0A5);
    wait_done("post_rst", 200);
    check_line("post_rst");
    check("post_rst_grant0", at(grant_log, 0), 0);
    check("post_rst_grant1", at(grant_log, 1), 1);

    // Round-robin fairness: two frames queued on each source
    clear_logs();
    push_byte(0, 8'h01, 1'b0, 1'b0); push_byte(0, 8'h02, 1'b1, 1'b0);
    push_byte(0, 8'h03, 1'b0, 1'b0); push_byte(0, 8'h04, 1'b1, 1'b0);
    push_byte(1, 8'hF1, 1'b0, 1'b0); push_byte(1, 8'hF2, 1'b1, 1'b0);
    push_byte(1, 8'hF3, 1'b0, 1'b0); push_byte(1, 8'hF4, 1'b1, 1'b0);
    exp_preamble(); exp_q.push_back(9'h001); exp_q.push_back(9'h002);
    exp_preamble(); exp_q.push_back(9'h0F1); exp_q.push_back(9'h0F2);
    exp_preamble(); exp_q.push_back(9'h003); exp_q.push_back(9'h004);
    exp_preamble(); exp_q.push_back(9'h0F3); exp_q.push_back(9'h0F4);
    wait_done("rr", 400);
    check_line("rr");
    check("rr_grant0", at(grant_log, 0), 0);
    check("rr_grant1", at(grant_log, 1), 1);
    check("rr_grant2", at(grant_log, 2), 0);
    check("rr_grant3", at(grant_log, 3), 1);

    // 64-byte frame with valid always high
    clear_logs();
    exp_preamble();
    for (int i = 0; i < 64; i++) begin
      push_byte(0, 8'(i * 5 + 3), (i == 63), 1'b0);
      exp_q.push_back({1'b0, 8'(i * 5 + 3)});
    end
    wait_done("long", 400);
    check_line("long");
    check("long_span", at(end_log, 0) - at(pre_log, 0) + 1, 72);
    check("long_ready_cycles", rdy_cnt0, 64);

    // Whole-run properties
    check("ready_only_granted", bad_ready, 0);
    check("tx_er_cycles", er_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
